// File: rtl/regfile_wb_ctrl_pkg.sv
// Shared core constants and types for the register-file write-back controller.
package regfile_wb_ctrl_pkg;

    localparam int unsigned NUM_REQ_DEF = 3;
    localparam int unsigned DATA_W_DEF  = 32;

    localparam int unsigned REQ_ALU = 0;
    localparam int unsigned REQ_LSU = 1;
    localparam int unsigned REQ_CSR = 2;

    typedef struct packed {
        logic                  valid;
        logic [4:0]            rd;
        logic [DATA_W_DEF-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts after the last granted index.
module rr_arbiter #(
    parameter int unsigned N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q, ptr_d;

    always_comb begin
        int idx;
        logic found;
        gnt   = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        for (int k = 1; k <= int'(N); k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= int'(N)) idx = idx - int'(N);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                ptr_d    = idx[PW-1:0];
                found    = 1'b1;
            end
        end
        // Nothing is granted while reset is held.
        if (rst) begin
            gnt   = '0;
            ptr_d = ptr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= PW'(N - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-back arbitration into the register file with per-register pending-write scoreboard.
module regfile_wb_ctrl
    import regfile_wb_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF,
    parameter int unsigned B_WIDTH = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                wb_valid,
    output logic [NUM_REQ-1:0]                wb_ready,
    input  logic [NUM_REQ-1:0][4:0]           wb_rd,
    input  logic [NUM_REQ-1:0][B_WIDTH-1:0]   wb_data,
    input  logic                              iss_valid,
    input  logic [4:0]                        iss_rd,
    output logic                              iss_ready,
    input  logic [4:0]                        rs1_addr,
    input  logic [4:0]                        rs2_addr,
    output logic                              hazard,
    output logic                              write_en,
    output logic [4:0]                        rd_addr,
    output logic [B_WIDTH-1:0]                rd_data
);

    logic [1:0]         pend_q [32];
    logic [1:0]         pend_d [32];
    logic [NUM_REQ-1:0] gnt;
    logic               granted;
    logic [4:0]         g_rd;
    logic [B_WIDTH-1:0] g_data;
    logic               inc, dec;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .clk (clk),
        .rst (rst),
        .req (wb_valid),
        .gnt (gnt)
    );

    assign wb_ready = gnt;
    assign granted  = |gnt;

    always_comb begin
        g_rd   = '0;
        g_data = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (gnt[i]) begin
                g_rd   = wb_rd[i];
                g_data = wb_data[i];
            end
        end
    end

    // A zero counter is never decremented; such a write still goes to the file.
    assign dec = granted && (g_rd != 5'd0) && (pend_q[g_rd] != 2'd0);

    always_comb begin
        iss_ready = !rst;
        if (pend_q[iss_rd] == 2'd3 && !(dec && g_rd == iss_rd)) begin
            iss_ready = 1'b0;
        end
    end

    assign inc = iss_valid && iss_ready && (iss_rd != 5'd0);

    always_comb begin
        for (int r = 0; r < 32; r++) begin
            pend_d[r] = pend_q[r];
        end
        if (!(inc && dec && iss_rd == g_rd)) begin
            if (inc) pend_d[iss_rd] = pend_q[iss_rd] + 2'd1;
            if (dec) pend_d[g_rd]   = pend_q[g_rd] - 2'd1;
        end
        pend_d[0] = 2'd0;
    end

    assign hazard = ((rs1_addr != 5'd0) && (pend_q[rs1_addr] != 2'd0)) ||
                    ((rs2_addr != 5'd0) && (pend_q[rs2_addr] != 2'd0));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 32; r++) begin
                pend_q[r] <= 2'd0;
            end
            write_en <= 1'b0;
            rd_addr  <= '0;
            rd_data  <= '0;
        end else begin
            for (int r = 0; r < 32; r++) begin
                pend_q[r] <= pend_d[r];
            end
            write_en <= granted && (g_rd != 5'd0);
            if (granted) begin
                rd_addr <= g_rd;
                rd_data <= g_data;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed, table-driven bench for regfile_wb_ctrl with hand sequences for multi-cycle corners.
module tb_regfile_wb_ctrl;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0]       wb_valid;
    logic [2:0]       wb_ready;
    logic [2:0][4:0]  wb_rd;
    logic [2:0][31:0] wb_data;
    logic             iss_valid;
    logic [4:0]       iss_rd;
    logic             iss_ready;
    logic [4:0]       rs1_addr, rs2_addr;
    logic             hazard;
    logic             write_en;
    logic [4:0]       rd_addr;
    logic [31:0]      rd_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    regfile_wb_ctrl #(
        .NUM_REQ (3),
        .B_WIDTH (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_ready (iss_ready),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .hazard    (hazard),
        .write_en  (write_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

    typedef struct {
        logic [2:0]  valid;
        logic        iv;
        logic [4:0]  ird;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  e_rdy;
        logic        e_iss;
        logic        e_haz;
        logic        e_we;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        wb_valid  = '0;
        iss_valid = 1'b0;
        iss_rd    = '0;
        rs1_addr  = '0;
        rs2_addr  = '0;
        for (int i = 0; i < 3; i++) begin
            wb_rd[i]   = 5'(10 + i);
            wb_data[i] = 32'hA000_0000 + 32'(i);
        end

        vecs[0]  = '{3'b111, 1'b0, 5'd0,  5'd10, 5'd0,  3'b001, 1'b1, 1'b0, 1'b0, 5'd0,  32'h0};
        vecs[1]  = '{3'b111, 1'b0, 5'd0,  5'd10, 5'd0,  3'b010, 1'b1, 1'b0, 1'b1, 5'd10, 32'hA000_0000};
        vecs[2]  = '{3'b111, 1'b0, 5'd0,  5'd10, 5'd0,  3'b100, 1'b1, 1'b0, 1'b1, 5'd11, 32'hA000_0001};
        vecs[3]  = '{3'b111, 1'b0, 5'd0,  5'd10, 5'd0,  3'b001, 1'b1, 1'b0, 1'b1, 5'd12, 32'hA000_0002};
        vecs[4]  = '{3'b111, 1'b0, 5'd0,  5'd10, 5'd0,  3'b010, 1'b1, 1'b0, 1'b1, 5'd10, 32'hA000_0000};
        vecs[5]  = '{3'b111, 1'b0, 5'd0,  5'd10, 5'd0,  3'b100, 1'b1, 1'b0, 1'b1, 5'd11, 32'hA000_0001};
        vecs[6]  = '{3'b000, 1'b0, 5'd0,  5'd10, 5'd0,  3'b000, 1'b1, 1'b0, 1'b1, 5'd12, 32'hA000_0002};
        vecs[7]  = '{3'b000, 1'b1, 5'd10, 5'd10, 5'd0,  3'b000, 1'b1, 1'b0, 1'b0, 5'd0,  32'h0};
        vecs[8]  = '{3'b000, 1'b0, 5'd0,  5'd10, 5'd0,  3'b000, 1'b1, 1'b1, 1'b0, 5'd0,  32'h0};
        vecs[9]  = '{3'b000, 1'b0, 5'd0,  5'd0,  5'd10, 3'b000, 1'b1, 1'b1, 1'b0, 5'd0,  32'h0};
        vecs[10] = '{3'b001, 1'b0, 5'd0,  5'd10, 5'd0,  3'b001, 1'b1, 1'b1, 1'b0, 5'd0,  32'h0};
        vecs[11] = '{3'b000, 1'b0, 5'd0,  5'd10, 5'd0,  3'b000, 1'b1, 1'b0, 1'b1, 5'd10, 32'hA000_0000};

        tick();
        tick();
        @(negedge clk);
        check("rst_wb_ready", 32'(wb_ready), 32'h0);
        check("rst_iss_ready", 32'(iss_ready), 32'h0);
        check("rst_write_en", 32'(write_en), 32'h0);
        check("rst_rd_addr", 32'(rd_addr), 32'h0);
        check("rst_rd_data", rd_data, 32'h0);
        tick();
        rst = 1'b0;

        // Round-robin over all requesters, then a scoreboard round trip on x10.
        for (int v = 0; v < 12; v++) begin
            wb_valid  = vecs[v].valid;
            iss_valid = vecs[v].iv;
            iss_rd    = vecs[v].ird;
            rs1_addr  = vecs[v].rs1;
            rs2_addr  = vecs[v].rs2;
            @(negedge clk);
            check($sformatf("vec%0d_wb_ready", v), 32'(wb_ready), 32'(vecs[v].e_rdy));
            check($sformatf("vec%0d_iss_ready", v), 32'(iss_ready), 32'(vecs[v].e_iss));
            check($sformatf("vec%0d_hazard", v), 32'(hazard), 32'(vecs[v].e_haz));
            check($sformatf("vec%0d_write_en", v), 32'(write_en), 32'(vecs[v].e_we));
            if (vecs[v].e_we) begin
                check($sformatf("vec%0d_rd_addr", v), 32'(rd_addr), 32'(vecs[v].e_addr));
                check($sformatf("vec%0d_rd_data", v), rd_data, vecs[v].e_data);
            end
            tick();
        end

        // LSU write clears a RAW hazard on x5; pointer currently at 0.
        wb_valid = '0;
        wb_rd[1] = 5'd5;
        wb_data[1] = 32'hDEAD_BEEF;
        iss_valid = 1'b1; iss_rd = 5'd5; rs1_addr = 5'd0; rs2_addr = 5'd0;
        @(negedge clk);
        check("a_iss_ready", 32'(iss_ready), 32'h1);
        check("a_hazard_pre", 32'(hazard), 32'h0);
        tick();
        iss_valid = 1'b0; iss_rd = 5'd0; rs1_addr = 5'd5;
        @(negedge clk);
        check("a_hazard_set", 32'(hazard), 32'h1);
        tick();
        wb_valid = 3'b010;
        @(negedge clk);
        check("a_wb_ready", 32'(wb_ready), 32'h2);
        check("a_hazard_grant_cycle", 32'(hazard), 32'h1);
        tick();
        wb_valid = '0;
        @(negedge clk);
        check("a_hazard_clear", 32'(hazard), 32'h0);
        check("a_write_en", 32'(write_en), 32'h1);
        check("a_rd_addr", 32'(rd_addr), 32'd5);
        check("a_rd_data", rd_data, 32'hDEAD_BEEF);
        tick();

        // Saturate x7, then a same-register grant lets the fourth issue in.
        wb_rd[1] = 5'd7;
        wb_data[1] = 32'h77;
        rs1_addr = 5'd0;
        for (int n = 0; n < 3; n++) begin
            iss_valid = 1'b1; iss_rd = 5'd7;
            @(negedge clk);
            check($sformatf("b_issue%0d_ready", n), 32'(iss_ready), 32'h1);
            tick();
        end
        rs1_addr = 5'd7;
        @(negedge clk);
        check("b_full_iss_ready", 32'(iss_ready), 32'h0);
        check("b_full_hazard", 32'(hazard), 32'h1);
        tick();
        wb_valid = 3'b010;
        @(negedge clk);
        check("b_grant_wb_ready", 32'(wb_ready), 32'h2);
        check("b_same_reg_iss_ready", 32'(iss_ready), 32'h1);
        tick();
        wb_valid = '0;
        @(negedge clk);
        check("b_still_full_iss_ready", 32'(iss_ready), 32'h0);
        check("b_write_en", 32'(write_en), 32'h1);
        check("b_rd_addr", 32'(rd_addr), 32'd7);
        tick();
        iss_valid = 1'b0;

        // ALU write to x0: no register write, but the pointer still moves.
        wb_rd[0] = 5'd0;
        wb_data[0] = 32'h1234;
        wb_valid = 3'b001; iss_valid = 1'b1; iss_rd = 5'd0; rs1_addr = 5'd0;
        @(negedge clk);
        check("c_wb_ready", 32'(wb_ready), 32'h1);
        check("c_iss_ready_x0", 32'(iss_ready), 32'h1);
        check("c_hazard_x0", 32'(hazard), 32'h0);
        tick();
        wb_valid = 3'b111; iss_valid = 1'b0;
        @(negedge clk);
        check("c_write_en_x0", 32'(write_en), 32'h0);
        check("c_hazard_after", 32'(hazard), 32'h0);
        check("c_ptr_advanced", 32'(wb_ready), 32'h2);
        tick();
        wb_valid = '0;

        // Reset with pending issues and a write in flight.
        wb_rd[0] = 5'd3;
        iss_valid = 1'b1; iss_rd = 5'd9; rs1_addr = 5'd9; rs2_addr = 5'd7;
        @(negedge clk);
        check("d_issue1_ready", 32'(iss_ready), 32'h1);
        tick();
        wb_valid = 3'b001;
        @(negedge clk);
        check("d_hazard_pending", 32'(hazard), 32'h1);
        check("d_pre_rst_wb_ready", 32'(wb_ready), 32'h1);
        tick();
        rst = 1'b1; iss_valid = 1'b0; wb_valid = 3'b111;
        @(negedge clk);
        check("d_rst_wb_ready", 32'(wb_ready), 32'h0);
        check("d_rst_iss_ready", 32'(iss_ready), 32'h0);
        check("d_inflight_write_en", 32'(write_en), 32'h1);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("d_hazard_cleared", 32'(hazard), 32'h0);
        check("d_write_en_cleared", 32'(write_en), 32'h0);
        check("d_first_grant", 32'(wb_ready), 32'h1);
        tick();
        wb_valid = '0;
        @(negedge clk);
        check("d_first_write_en", 32'(write_en), 32'h1);
        check("d_first_rd_addr", 32'(rd_addr), 32'd3);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
